// File: rtl/dco_tune_ctrl.sv
// DCO tuning controller: coarse-band acquisition FSM followed by fine tracking of the loop filter output.
// Optional first-order dither of the dropped filter LSBs is enabled by defining DCO_DITHER_EN.
module dco_tune_ctrl #(
    parameter int IN_W        = 8,
    parameter int COARSE_W    = 5,
    parameter int FINE_W      = 6,
    parameter int COARSE_INIT = 16,
    parameter int SETTLE_CYC  = 64,
    parameter int HI_TH       = 192,
    parameter int LO_TH       = 64,
    parameter int LOCK_CYC    = 256,
    parameter int RAIL_CYC    = 128
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [IN_W-1:0]     filt_in,
    output logic [COARSE_W-1:0] coarse_out,
    output logic [FINE_W-1:0]   fine_out,
    output logic                locked,
    output logic                coarse_sat,
    output logic [1:0]          state_out
);

    localparam int TMR_W  = $clog2(SETTLE_CYC);
    localparam int LCK_W  = $clog2(LOCK_CYC + 1);
    localparam int RAIL_W = $clog2(RAIL_CYC + 1);

    localparam logic [FINE_W-1:0]   FINE_MID   = {1'b1, {(FINE_W-1){1'b0}}};
    localparam logic [COARSE_W-1:0] COARSE_MAX = {COARSE_W{1'b1}};
    localparam logic [COARSE_W-1:0] COARSE_RST = COARSE_W'(COARSE_INIT);
    localparam logic [IN_W-1:0]     HI_TH_V    = IN_W'(HI_TH);
    localparam logic [IN_W-1:0]     LO_TH_V    = IN_W'(LO_TH);
    localparam logic [TMR_W-1:0]    TMR_LAST   = TMR_W'(SETTLE_CYC - 1);
    localparam logic [LCK_W-1:0]    LOCK_MAX   = LCK_W'(LOCK_CYC);
    localparam logic [LCK_W-1:0]    LOCK_PRE   = LCK_W'(LOCK_CYC - 1);
    localparam logic [RAIL_W-1:0]   RAIL_LAST  = RAIL_W'(RAIL_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_TRACK  = 2'd2,
        ST_RELOCK = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [COARSE_W-1:0] coarse_q, coarse_d;
    logic [FINE_W-1:0]   fine_q, fine_d;
    logic                locked_q, locked_d;
    logic                sat_q, sat_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [LCK_W-1:0]    lock_cnt_q, lock_cnt_d;
    logic [RAIL_W-1:0]   rail_q, rail_d;
    logic [FINE_W-1:0]   fine_trk_s;
    logic                in_win_s;
    logic                railed_s;
    logic                unused_lsb_s;

`ifdef DCO_DITHER_EN
    logic [2:0]          acc_q, acc_d;
    logic [2:0]          dith_sum_s;
    logic [FINE_W:0]     fine_sum_s;

    // Sigma-delta on the two dropped LSBs; the carry bumps the fine word for one cycle.
    always_comb begin
        dith_sum_s   = {1'b0, acc_q[1:0]} + {1'b0, filt_in[1:0]};
        fine_sum_s   = {1'b0, filt_in[IN_W-1:2]} + {{FINE_W{1'b0}}, dith_sum_s[2]};
        unused_lsb_s = acc_q[2];
        if (fine_sum_s[FINE_W]) begin
            fine_trk_s = {FINE_W{1'b1}};
        end else begin
            fine_trk_s = fine_sum_s[FINE_W-1:0];
        end
    end
`else
    // Plain truncation of the filter word onto the fine tuning range.
    always_comb begin
        fine_trk_s   = filt_in[IN_W-1:2];
        unused_lsb_s = ^filt_in[1:0];
    end
`endif

    assign in_win_s = (filt_in >= LO_TH_V) && (filt_in <= HI_TH_V);
    assign railed_s = (filt_in == {IN_W{1'b0}}) || (filt_in == {IN_W{1'b1}});

    // Next-state and next-output logic for the acquisition/tracking loop.
    always_comb begin
        state_d    = state_q;
        coarse_d   = coarse_q;
        fine_d     = fine_q;
        locked_d   = locked_q;
        sat_d      = sat_q;
        tmr_d      = tmr_q;
        lock_cnt_d = lock_cnt_q;
        rail_d     = rail_q;
`ifdef DCO_DITHER_EN
        acc_d      = 3'd0;
`endif
        if (!en) begin
            state_d    = ST_IDLE;
            coarse_d   = COARSE_RST;
            fine_d     = FINE_MID;
            locked_d   = 1'b0;
            sat_d      = 1'b0;
            tmr_d      = '0;
            lock_cnt_d = '0;
            rail_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_ACQ;
                    coarse_d   = COARSE_RST;
                    fine_d     = FINE_MID;
                    locked_d   = 1'b0;
                    sat_d      = 1'b0;
                    tmr_d      = '0;
                    lock_cnt_d = '0;
                    rail_d     = '0;
                end
                ST_ACQ: begin
                    fine_d     = FINE_MID;
                    locked_d   = 1'b0;
                    lock_cnt_d = '0;
                    rail_d     = '0;
                    if (tmr_q == TMR_LAST) begin
                        tmr_d = '0;
                        if (filt_in > HI_TH_V) begin
                            if (coarse_q == COARSE_MAX) begin
                                sat_d = 1'b1;
                            end else begin
                                coarse_d = coarse_q + 1'b1;
                                sat_d    = 1'b0;
                            end
                        end else if (filt_in < LO_TH_V) begin
                            if (coarse_q == {COARSE_W{1'b0}}) begin
                                sat_d = 1'b1;
                            end else begin
                                coarse_d = coarse_q - 1'b1;
                                sat_d    = 1'b0;
                            end
                        end else begin
                            state_d = ST_TRACK;
                            sat_d   = 1'b0;
                        end
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                ST_TRACK: begin
                    fine_d = fine_trk_s;
                    tmr_d  = '0;
`ifdef DCO_DITHER_EN
                    acc_d  = dith_sum_s;
`endif
                    if (in_win_s) begin
                        if (lock_cnt_q == LOCK_MAX) begin
                            lock_cnt_d = lock_cnt_q;
                        end else begin
                            lock_cnt_d = lock_cnt_q + 1'b1;
                        end
                        locked_d = (lock_cnt_q >= LOCK_PRE);
                    end else begin
                        lock_cnt_d = '0;
                        locked_d   = 1'b0;
                    end
                    // A persistently railed filter means the band is wrong: hand back to acquisition.
                    if (railed_s) begin
                        if (rail_q == RAIL_LAST) begin
                            state_d    = ST_RELOCK;
                            rail_d     = '0;
                            lock_cnt_d = '0;
                            locked_d   = 1'b0;
                            fine_d     = FINE_MID;
`ifdef DCO_DITHER_EN
                            acc_d      = 3'd0;
`endif
                        end else begin
                            rail_d = rail_q + 1'b1;
                        end
                    end else begin
                        rail_d = '0;
                    end
                end
                ST_RELOCK: begin
                    state_d    = ST_ACQ;
                    fine_d     = FINE_MID;
                    locked_d   = 1'b0;
                    tmr_d      = '0;
                    lock_cnt_d = '0;
                    rail_d     = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            coarse_q   <= COARSE_RST;
            fine_q     <= FINE_MID;
            locked_q   <= 1'b0;
            sat_q      <= 1'b0;
            tmr_q      <= '0;
            lock_cnt_q <= '0;
            rail_q     <= '0;
`ifdef DCO_DITHER_EN
            acc_q      <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            coarse_q   <= coarse_d;
            fine_q     <= fine_d;
            locked_q   <= locked_d;
            sat_q      <= sat_d;
            tmr_q      <= tmr_d;
            lock_cnt_q <= lock_cnt_d;
            rail_q     <= rail_d;
`ifdef DCO_DITHER_EN
            acc_q      <= acc_d;
`endif
        end
    end

    assign coarse_out = coarse_q;
    assign fine_out   = fine_q;
    assign locked     = locked_q;
    assign coarse_sat = sat_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_dco_tune_ctrl.sv
// Directed bench for dco_tune_ctrl: acquisition, tracking, lock, rail re-acquisition, enable and async reset.
module tb_dco_tune_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] filt_in;
    logic [4:0] coarse_out;
    logic [5:0] fine_out;
    logic       locked;
    logic       coarse_sat;
    logic [1:0] state_out;

    int n_checks;
    int n_fails;

    dco_tune_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .filt_in    (filt_in),
        .coarse_out (coarse_out),
        .fine_out   (fine_out),
        .locked     (locked),
        .coarse_sat (coarse_sat),
        .state_out  (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, landing on the following falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        filt_in  = 8'h80;
        tick(2);
        check("rst_state", 32'(state_out), 32'd0);
        check("rst_coarse", 32'(coarse_out), 32'd16);
        check("rst_fine", 32'(fine_out), 32'd32);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_sat", 32'(coarse_sat), 32'd0);

        // Coarse acquisition upward until saturation.
        rst_n   = 1'b1;
        en      = 1'b1;
        filt_in = 8'hF0;
        tick(1);
        check("acq_enter", 32'(state_out), 32'd1);
        tick(63);
        check("acq_pre_step", 32'(coarse_out), 32'd16);
        tick(1);
        check("acq_step1", 32'(coarse_out), 32'd17);
        tick(64 * 14);
        check("acq_reach_max", 32'(coarse_out), 32'd31);
        check("acq_sat_clear", 32'(coarse_sat), 32'd0);
        tick(64);
        check("acq_hold_max", 32'(coarse_out), 32'd31);
        check("acq_sat_set", 32'(coarse_sat), 32'd1);
        check("acq_still", 32'(state_out), 32'd1);

        // Step down clears saturation.
        filt_in = 8'h10;
        tick(64);
        check("acq_down", 32'(coarse_out), 32'd30);
        check("acq_down_sat", 32'(coarse_sat), 32'd0);

        // In-range filter at terminal count enters TRACK.
        filt_in = 8'h80;
        tick(64);
        check("trk_enter", 32'(state_out), 32'd2);
        check("trk_coarse", 32'(coarse_out), 32'd30);
        tick(1);
        check("trk_fine_mid", 32'(fine_out), 32'h20);
        tick(254);
        check("trk_not_locked", 32'(locked), 32'd0);
        tick(1);
        check("trk_locked", 32'(locked), 32'd1);

        filt_in = 8'hA4;
        tick(1);
        check("trk_fine_a4", 32'(fine_out), 32'h29);
        check("trk_lock_hold", 32'(locked), 32'd1);

        // Constant 0x81: dither spreads the LSBs, truncation gives a flat word.
        filt_in = 8'h81;
        for (int i = 0; i < 4; i++) begin
            tick(1);
`ifdef DCO_DITHER_EN
            check("trk_dither", 32'(fine_out), (i == 3) ? 32'h21 : 32'h20);
`else
            check("trk_trunc", 32'(fine_out), 32'h20);
`endif
        end

        filt_in = 8'h30;
        tick(1);
        check("trk_out_win_lock", 32'(locked), 32'd0);
        check("trk_fine_30", 32'(fine_out), 32'h0C);
        check("trk_out_win_state", 32'(state_out), 32'd2);

        // Relock, then rail the filter high.
        filt_in = 8'h80;
        tick(256);
        check("trk_relock", 32'(locked), 32'd1);
        filt_in = 8'hFF;
        tick(1);
        check("rail_unlock", 32'(locked), 32'd0);
        check("rail_fine", 32'(fine_out), 32'h3F);
        tick(126);
        check("rail_pre", 32'(state_out), 32'd2);
        tick(1);
        check("rail_relock", 32'(state_out), 32'd3);
        check("rail_relock_fine", 32'(fine_out), 32'd32);
        check("rail_relock_coarse", 32'(coarse_out), 32'd30);
        tick(1);
        check("rail_to_acq", 32'(state_out), 32'd1);
        check("rail_acq_coarse", 32'(coarse_out), 32'd30);

        // Back to TRACK and lock, then drop enable.
        filt_in = 8'h80;
        tick(64);
        check("re_track", 32'(state_out), 32'd2);
        tick(256);
        check("re_locked", 32'(locked), 32'd1);
        filt_in = 8'hA0;
        tick(1);
        check("re_fine_a0", 32'(fine_out), 32'h28);
        en = 1'b0;
        tick(1);
        check("dis_state", 32'(state_out), 32'd0);
        check("dis_coarse", 32'(coarse_out), 32'd16);
        check("dis_fine", 32'(fine_out), 32'd32);
        check("dis_locked", 32'(locked), 32'd0);
        en      = 1'b1;
        filt_in = 8'hF0;
        tick(1);
        check("en_acq", 32'(state_out), 32'd1);
        tick(64);
        check("en_step", 32'(coarse_out), 32'd17);

        // Asynchronous reset between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(state_out), 32'd0);
        check("arst_coarse", 32'(coarse_out), 32'd16);
        check("arst_fine", 32'(fine_out), 32'd32);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("arst_resume", 32'(state_out), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
